timer0_counter_unit: RTL and testbench



---
 rtl/timer0_pkg.sv | 39 +++
 rtl/timer0_counter_unit_if.sv | 44 ++++
 rtl/oc0_waveform_gen.sv | 76 +++++++
 rtl/timer0_counter_unit.sv | 162 ++++++++++++++++
 tb/tb_timer0_counter_unit.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer0_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : timer0_pkg                                                   |
// | Purpose : Shared encodings and constants for the Timer0 counting core  |
// |           (waveform modes, compare-output modes, count direction).     |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
package timer0_pkg;

  localparam int TIMER0_WIDTH = 8;
  localparam logic [TIMER0_WIDTH-1:0] TIMER0_MAX    = {TIMER0_WIDTH{1'b1}};
  localparam logic [TIMER0_WIDTH-1:0] TIMER0_BOTTOM = '0;

  typedef enum logic [1:0] {
    WGM_NORMAL = 2'b00,
    WGM_PCPWM  = 2'b01,
    WGM_CTC    = 2'b10,
    WGM_FPWM   = 2'b11
  } wgm_e;

  typedef enum logic [1:0] {
    COM_OFF    = 2'b00,
    COM_TOGGLE = 2'b01,
    COM_CLEAR  = 2'b10,
    COM_SET    = 2'b11
  } com_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Both PWM encodings have bit 0 set; normal and CTC have it clear.
  function automatic logic is_pwm(input logic [1:0] wgm);
    return wgm[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/timer0_counter_unit_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface: timer0_counter_unit_if                                      |
// | Purpose  : Control/status bundle between the Timer0 register logic     |
// |            (master) and the counting core (slave).                     |
// | Ports    : tick, wgm, com, tcnt_we/wdata, ocr_we/wdata, foc, tov_clr,  |
// |            ocf_clr (to core); tcnt, ocr, tov_flag, ocf_flag, oc0 (from |
// |            core).                                                      |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
interface timer0_counter_unit_if #(
  parameter int WIDTH = 8
);

  logic             tick;
  logic [1:0]       wgm;
  logic [1:0]       com;
  logic             tcnt_we;
  logic [WIDTH-1:0] tcnt_wdata;
  logic             ocr_we;
  logic [WIDTH-1:0] ocr_wdata;
  logic             foc;
  logic             tov_clr;
  logic             ocf_clr;
  logic [WIDTH-1:0] tcnt;
  logic [WIDTH-1:0] ocr;
  logic             tov_flag;
  logic             ocf_flag;
  logic             oc0;

  modport master (
    output tick, wgm, com, tcnt_we, tcnt_wdata, ocr_we, ocr_wdata,
           foc, tov_clr, ocf_clr,
    input  tcnt, ocr, tov_flag, ocf_flag, oc0
  );

  modport slave (
    input  tick, wgm, com, tcnt_we, tcnt_wdata, ocr_we, ocr_wdata,
           foc, tov_clr, ocf_clr,
    output tcnt, ocr, tov_flag, ocf_flag, oc0
  );

endinterface
`default_nettype wire

// File: rtl/oc0_waveform_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : oc0_waveform_gen                                             |
// | Purpose : Holds the OC0 output register and applies the compare-output |
// |           action selected by wgm/com on match, BOTTOM and force events.|
// | Ports   : sysClock, reset, match (qualified ticked match), bottom      |
// |           (fast-PWM wrap), dir (count direction before the tick),      |
// |           foc, wgm, com -> oc0.                                        |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module oc0_waveform_gen
  import timer0_pkg::*;
(
  input  logic       sysClock,
  input  logic       reset,
  input  logic       match,
  input  logic       bottom,
  input  dir_e       dir,
  input  logic       foc,
  input  logic [1:0] wgm,
  input  logic [1:0] com,
  output logic       oc0
);

  logic r_oc0;
  wgm_e w_wgm;
  com_e w_com;
  logic w_act;

  assign w_wgm = wgm_e'(wgm);
  assign w_com = com_e'(com);
  // A forced compare behaves exactly like a real match, but only outside PWM.
  assign w_act = match | foc;

  always_ff @(posedge sysClock) begin
    if (reset) begin
      r_oc0 <= 1'b0;
    end else begin
      case (w_wgm)
        WGM_NORMAL, WGM_CTC: begin
          case (w_com)
            COM_OFF:    r_oc0 <= 1'b0;
            COM_TOGGLE: if (w_act) r_oc0 <= ~r_oc0;
            COM_CLEAR:  if (w_act) r_oc0 <= 1'b0;
            COM_SET:    if (w_act) r_oc0 <= 1'b1;
          endcase
        end
        WGM_FPWM: begin
          // BOTTOM is checked first so it wins when ocr == MAX.
          case (w_com)
            COM_CLEAR: begin
              if (bottom)     r_oc0 <= 1'b1;
              else if (match) r_oc0 <= 1'b0;
            end
            COM_SET: begin
              if (bottom)     r_oc0 <= 1'b0;
              else if (match) r_oc0 <= 1'b1;
            end
            default:          r_oc0 <= 1'b0;
          endcase
        end
        WGM_PCPWM: begin
          case (w_com)
            COM_CLEAR: if (match) r_oc0 <= (dir == DIR_DOWN);
            COM_SET:   if (match) r_oc0 <= (dir == DIR_UP);
            default:              r_oc0 <= 1'b0;
          endcase
        end
      endcase
    end
  end

  assign oc0 = r_oc0;

endmodule
`default_nettype wire

// File: rtl/timer0_counter_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : timer0_counter_unit                                          |
// | Purpose : Timer0 TCNT0 counting core. Advances the count once per      |
// |           accepted prescaler tick in normal, CTC, fast PWM and         |
// |           phase-correct PWM modes; double-buffers OCR0 in PWM modes;   |
// |           raises TOV0/OCF0 and drives the OC0 waveform.                |
// | Ports   : sysClock, reset (sync, active-high), bus (slave modport of   |
// |           timer0_counter_unit_if).                                     |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module timer0_counter_unit
  import timer0_pkg::*;
#(
  parameter int WIDTH = TIMER0_WIDTH
) (
  input  logic                  sysClock,
  input  logic                  reset,
  timer0_counter_unit_if.slave  bus
);

  localparam logic [WIDTH-1:0] c_MAX    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_BOTTOM = '0;
  localparam logic [WIDTH-1:0] c_ONE    = WIDTH'(1);

  logic [WIDTH-1:0] r_tcnt;
  logic [WIDTH-1:0] r_ocr;
  logic [WIDTH-1:0] r_ocr_buf;
  logic             r_tov;
  logic             r_ocf;
  logic             r_block;
  dir_e             r_dir;

  wgm_e             w_wgm;
  logic             w_pwm;
  logic             w_tick_acc;
  logic             w_at_max;
  logic             w_at_bottom;
  logic             w_raw_match;
  logic             w_match;
  logic [WIDTH-1:0] w_tcnt_next;
  dir_e             w_dir_next;
  logic             w_tov_set;
  logic             w_ocr_load;
  logic             w_bottom;
  logic             w_oc0;

  assign w_wgm       = wgm_e'(bus.wgm);
  assign w_pwm       = is_pwm(bus.wgm);
  // A CPU write to TCNT0 swallows any tick arriving in the same cycle.
  assign w_tick_acc  = bus.tick & ~bus.tcnt_we;
  assign w_at_max    = (r_tcnt == c_MAX);
  assign w_at_bottom = (r_tcnt == c_BOTTOM);
  assign w_raw_match = (r_tcnt == r_ocr);
  // The first tick after a TCNT0 write never reports a compare match.
  assign w_match     = w_tick_acc & w_raw_match & ~r_block;

  always_comb begin
    w_tcnt_next = r_tcnt;
    w_dir_next  = r_dir;
    w_tov_set   = 1'b0;
    w_ocr_load  = 1'b0;
    w_bottom    = 1'b0;
    if (w_tick_acc) begin
      case (w_wgm)
        WGM_NORMAL: begin
          w_tcnt_next = r_tcnt + c_ONE;
          w_tov_set   = w_at_max;
        end
        WGM_CTC: begin
          w_tcnt_next = w_raw_match ? c_BOTTOM : r_tcnt + c_ONE;
          w_tov_set   = w_at_max;
        end
        WGM_FPWM: begin
          w_tcnt_next = r_tcnt + c_ONE;
          if (w_at_max) begin
            w_tov_set  = 1'b1;
            w_ocr_load = 1'b1;
            w_bottom   = 1'b1;
          end
        end
        WGM_PCPWM: begin
          if (r_dir == DIR_UP) begin
            if (w_at_max) begin
              w_dir_next  = DIR_DOWN;
              w_tcnt_next = c_MAX - c_ONE;
              w_ocr_load  = 1'b1;
            end else begin
              w_tcnt_next = r_tcnt + c_ONE;
            end
          end else begin
            if (w_at_bottom) begin
              w_dir_next  = DIR_UP;
              w_tcnt_next = c_ONE;
              w_tov_set   = 1'b1;
            end else begin
              w_tcnt_next = r_tcnt - c_ONE;
            end
          end
        end
      endcase
    end
    if (w_wgm != WGM_PCPWM) begin
      w_dir_next = DIR_UP;
    end
  end

  always_ff @(posedge sysClock) begin
    if (reset) begin
      r_tcnt    <= '0;
      r_ocr     <= '0;
      r_ocr_buf <= '0;
      r_tov     <= 1'b0;
      r_ocf     <= 1'b0;
      r_block   <= 1'b0;
      r_dir     <= DIR_UP;
    end else begin
      r_tcnt <= bus.tcnt_we ? bus.tcnt_wdata : w_tcnt_next;
      r_dir  <= w_dir_next;

      if (bus.tcnt_we) begin
        r_block <= 1'b1;
      end else if (bus.tick) begin
        r_block <= 1'b0;
      end

      if (bus.ocr_we) begin
        r_ocr_buf <= bus.ocr_wdata;
      end
      // The PWM reload uses the buffer contents from before any same-cycle write.
      if (bus.ocr_we && !w_pwm) begin
        r_ocr <= bus.ocr_wdata;
      end else if (w_ocr_load) begin
        r_ocr <= r_ocr_buf;
      end

      // Set has priority over a simultaneous clear.
      r_tov <= w_tov_set | (r_tov & ~bus.tov_clr);
      r_ocf <= w_match   | (r_ocf & ~bus.ocf_clr);
    end
  end

  oc0_waveform_gen u_oc0 (
    .sysClock (sysClock),
    .reset    (reset),
    .match    (w_match),
    .bottom   (w_bottom),
    .dir      (r_dir),
    .foc      (bus.foc),
    .wgm      (bus.wgm),
    .com      (bus.com),
    .oc0      (w_oc0)
  );

  assign bus.tcnt     = r_tcnt;
  assign bus.ocr      = r_ocr;
  assign bus.tov_flag = r_tov;
  assign bus.ocf_flag = r_ocf;
  assign bus.oc0      = w_oc0;

endmodule
`default_nettype wire

// File: tb/tb_timer0_counter_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_timer0_counter_unit                                       |
// | Purpose : Self-checking bench for timer0_counter_unit: directed mode   |
// |           scenarios plus random traffic, compared every cycle with a   |
// |           behavioural model of the counter.                            |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_timer0_counter_unit;

  logic sysClock;
  logic reset;

  timer0_counter_unit_if #(.WIDTH(8)) bus ();

  timer0_counter_unit #(.WIDTH(8)) dut (
    .sysClock (sysClock),
    .reset    (reset),
    .bus      (bus)
  );

  initial sysClock = 1'b0;
  always #5 sysClock = ~sysClock;

  int n_assert = 0;
  int n_fail   = 0;
  int hi_cnt   = 0;

  // Behavioural model state
  int m_tcnt, m_ocr, m_buf;
  bit m_tov, m_ocf, m_oc0, m_up, m_blk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int  w  = int'(bus.wgm);
    int  cm = int'(bus.com);
    int  c;
    bit  hit, seen, bottom, tovs, load, was_up;
    seen = 0; bottom = 0; tovs = 0; load = 0;
    was_up = m_up;
    if (reset) begin
      m_tcnt = 0; m_ocr = 0; m_buf = 0;
      m_tov = 0; m_ocf = 0; m_oc0 = 0; m_up = 1; m_blk = 0;
      return;
    end
    if (bus.tcnt_we) begin
      m_tcnt = int'(bus.tcnt_wdata);
      m_blk  = 1;
    end else if (bus.tick) begin
      c    = m_tcnt;
      hit  = (c == m_ocr);
      seen = hit && !m_blk;
      m_blk = 0;
      if (w == 0) begin
        m_tcnt = (c + 1) % 256;
        tovs   = (c == 255);
      end else if (w == 2) begin
        m_tcnt = hit ? 0 : (c + 1) % 256;
        tovs   = (c == 255);
      end else if (w == 3) begin
        m_tcnt = (c + 1) % 256;
        if (c == 255) begin tovs = 1; load = 1; bottom = 1; end
      end else begin
        if (m_up) begin
          if (c == 255) begin m_up = 0; m_tcnt = 254; load = 1; end
          else m_tcnt = c + 1;
        end else begin
          if (c == 0) begin m_up = 1; m_tcnt = 1; tovs = 1; end
          else m_tcnt = c - 1;
        end
      end
    end
    if (w == 0 || w == 2) begin
      if (cm == 0) m_oc0 = 0;
      else if (seen || bus.foc) m_oc0 = (cm == 1) ? !m_oc0 : (cm == 3);
    end else if (cm == 0 || cm == 1) begin
      m_oc0 = 0;
    end else if (w == 3) begin
      if (bottom) m_oc0 = (cm == 2);
      else if (seen) m_oc0 = (cm == 3);
    end else if (seen) begin
      m_oc0 = (cm == 2) ? !was_up : was_up;
    end
    if (load) m_ocr = m_buf;
    if (bus.ocr_we) begin
      m_buf = int'(bus.ocr_wdata);
      if (w == 0 || w == 2) m_ocr = int'(bus.ocr_wdata);
    end
    m_tov = tovs || (m_tov && !bus.tov_clr);
    m_ocf = seen || (m_ocf && !bus.ocf_clr);
    if (w != 1) m_up = 1;
  endtask

  // One clock edge: update the model, sample the DUT 1 time unit later,
  // then drop all single-cycle pulses.
  task automatic cycle();
    @(posedge sysClock);
    model_edge();
    #1;
    chk("tcnt", int'(bus.tcnt), m_tcnt);
    chk("ocr",  int'(bus.ocr),  m_ocr);
    chk("tov",  int'(bus.tov_flag), int'(m_tov));
    chk("ocf",  int'(bus.ocf_flag), int'(m_ocf));
    chk("oc0",  int'(bus.oc0), int'(m_oc0));
    if (bus.oc0) hi_cnt++;
    bus.tcnt_we = 0; bus.ocr_we = 0; bus.foc = 0;
    bus.tov_clr = 0; bus.ocf_clr = 0;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    bus.tick = 0;
    reset = 1;
    cycle();
    reset = 0;
  endtask

  task automatic write_ocr(input int v);
    bus.ocr_wdata = 8'(v);
    bus.ocr_we    = 1;
    cycle();
  endtask

  initial begin
    reset = 1;
    bus.tick = 0; bus.wgm = 0; bus.com = 0;
    bus.tcnt_we = 0; bus.tcnt_wdata = 0; bus.ocr_we = 0; bus.ocr_wdata = 0;
    bus.foc = 0; bus.tov_clr = 0; bus.ocf_clr = 0;
    m_tcnt = 0; m_ocr = 0; m_buf = 0;
    m_tov = 0; m_ocf = 0; m_oc0 = 0; m_up = 1; m_blk = 0;

    // Reset state
    cycle();
    chk("rst_tcnt", int'(bus.tcnt), 0);
    chk("rst_ocr",  int'(bus.ocr), 0);
    chk("rst_flags", int'({bus.tov_flag, bus.ocf_flag, bus.oc0}), 0);
    reset = 0;

    // Normal mode, ocr = 0x10, tick held high
    bus.wgm = 2'b00; bus.com = 2'b01;
    write_ocr(8'h10);
    bus.tick = 1;
    run(16'h10);
    chk("norm_pre_ocf", int'(bus.ocf_flag), 0);
    run(1);
    chk("norm_tcnt11", int'(bus.tcnt), 8'h11);
    chk("norm_ocf", int'(bus.ocf_flag), 1);
    chk("norm_oc0_toggle", int'(bus.oc0), 1);
    run(8'hFF - 8'h11);
    chk("norm_tcntff", int'(bus.tcnt), 8'hFF);
    chk("norm_pre_tov", int'(bus.tov_flag), 0);
    run(1);
    chk("norm_wrap", int'(bus.tcnt), 0);
    chk("norm_tov", int'(bus.tov_flag), 1);

    // CTC mode, ocr = 5, toggle
    do_reset();
    bus.wgm = 2'b10; bus.com = 2'b01;
    write_ocr(5);
    bus.tick = 1;
    run(5);
    chk("ctc_tcnt5", int'(bus.tcnt), 5);
    chk("ctc_pre_ocf", int'(bus.ocf_flag), 0);
    run(1);
    chk("ctc_clear", int'(bus.tcnt), 0);
    chk("ctc_ocf", int'(bus.ocf_flag), 1);
    chk("ctc_oc0_1", int'(bus.oc0), 1);
    bus.ocf_clr = 1;
    run(1);
    chk("ctc_ocf_clr", int'(bus.ocf_flag), 0);
    run(5);
    chk("ctc_clear2", int'(bus.tcnt), 0);
    chk("ctc_ocf2", int'(bus.ocf_flag), 1);
    chk("ctc_oc0_0", int'(bus.oc0), 0);

    // Fast PWM, non-inverting, buffered OCR update mid-period
    do_reset();
    bus.wgm = 2'b11; bus.com = 2'b10;
    write_ocr(8'h40);
    chk("fpwm_ocr_buffered", int'(bus.ocr), 0);
    bus.tick = 1;
    run(256);
    chk("fpwm_bottom_oc0", int'(bus.oc0), 1);
    chk("fpwm_ocr_loaded", int'(bus.ocr), 8'h40);
    hi_cnt = 0;
    run(8'h60);
    bus.ocr_wdata = 8'h80; bus.ocr_we = 1;
    cycle();
    chk("fpwm_ocr_hold", int'(bus.ocr), 8'h40);
    run(256 - 8'h61);
    chk("fpwm_duty40", hi_cnt, 8'h41);
    chk("fpwm_ocr80", int'(bus.ocr), 8'h80);
    hi_cnt = 0;
    run(256);
    chk("fpwm_duty80", hi_cnt, 8'h81);

    // Phase-correct PWM, ocr = 0x80, non-inverting
    do_reset();
    bus.wgm = 2'b01; bus.com = 2'b10;
    write_ocr(8'h80);
    bus.tick = 1;
    run(255);
    chk("pc_peak", int'(bus.tcnt), 8'hFF);
    run(1);
    chk("pc_turn", int'(bus.tcnt), 8'hFE);
    chk("pc_ocr", int'(bus.ocr), 8'h80);
    run(126);
    chk("pc_pre_set", int'(bus.oc0), 0);
    run(1);
    chk("pc_down_tcnt", int'(bus.tcnt), 8'h7F);
    chk("pc_down_set", int'(bus.oc0), 1);
    run(127);
    chk("pc_bottom", int'(bus.tcnt), 0);
    chk("pc_no_tov", int'(bus.tov_flag), 0);
    run(1);
    chk("pc_up1", int'(bus.tcnt), 1);
    chk("pc_tov", int'(bus.tov_flag), 1);
    run(127);
    chk("pc_pre_clr", int'(bus.oc0), 1);
    run(1);
    chk("pc_up_clr", int'(bus.oc0), 0);

    // TCNT write blocks the next compare
    do_reset();
    bus.wgm = 2'b00; bus.com = 2'b01;
    write_ocr(8'h20);
    bus.tcnt_wdata = 8'h20; bus.tcnt_we = 1;
    cycle();
    chk("blk_write", int'(bus.tcnt), 8'h20);
    bus.tick = 1;
    cycle();
    chk("blk_ocf", int'(bus.ocf_flag), 0);
    chk("blk_oc0", int'(bus.oc0), 0);
    run(255);
    chk("blk_pre", int'(bus.ocf_flag), 0);
    run(1);
    chk("blk_after_ocf", int'(bus.ocf_flag), 1);
    chk("blk_after_oc0", int'(bus.oc0), 1);

    // Flag set beats clear; FOC in normal mode
    bus.tick = 0;
    bus.tov_clr = 1;
    cycle();
    chk("tov_cleared", int'(bus.tov_flag), 0);
    bus.tcnt_wdata = 8'hFF; bus.tcnt_we = 1;
    cycle();
    bus.tick = 1; bus.tov_clr = 1;
    cycle();
    chk("tov_set_wins", int'(bus.tov_flag), 1);
    bus.tick = 0; bus.foc = 1;
    cycle();
    chk("foc_toggle", int'(bus.oc0), 0);
    chk("foc_no_ocf", int'(bus.ocf_flag), 1);

    // Reset mid-count
    bus.tick = 1;
    run(7);
    reset = 1;
    cycle();
    reset = 0;
    chk("mid_rst", int'({bus.tcnt, bus.ocr, bus.tov_flag, bus.ocf_flag, bus.oc0}), 0);

    // Random traffic against the model
    for (int i = 0; i < 5000; i++) begin
      bus.tick       = ($urandom_range(0, 99) < 60);
      bus.tcnt_we    = ($urandom_range(0, 99) < 3);
      bus.tcnt_wdata = 8'($urandom);
      bus.ocr_we     = ($urandom_range(0, 99) < 5);
      bus.ocr_wdata  = 8'($urandom);
      bus.foc        = ($urandom_range(0, 99) < 3);
      bus.tov_clr    = ($urandom_range(0, 99) < 5);
      bus.ocf_clr    = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 199) == 0) bus.wgm = 2'($urandom);
      if ($urandom_range(0, 99) < 2)   bus.com = 2'($urandom);
      reset = ($urandom_range(0, 399) == 0);
      cycle();
    end
    reset = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
